// File: rtl/ysyx_23060278_decode_stage.sv
// Registered RV32/RV64 instruction-decode stage with a valid/ready output register and one-entry skid buffer.
// Optional illegal-instruction checking is enabled by defining YSYX_23060278_DEC_ILLEGAL_EN.
module ysyx_23060278_decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [5:0]      out_imm_type,
    output logic            out_word,
    output logic            out_illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("ysyx_23060278_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam bit IS64 = (XLEN == 64);

    // One-hot immediate format tags, ordered {R,I,S,B,U,J}
    localparam logic [5:0] FMT_R = 6'b100000;
    localparam logic [5:0] FMT_I = 6'b010000;
    localparam logic [5:0] FMT_S = 6'b001000;
    localparam logic [5:0] FMT_B = 6'b000100;
    localparam logic [5:0] FMT_U = 6'b000010;
    localparam logic [5:0] FMT_J = 6'b000001;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [5:0]      imm_type;
        logic            word;
        logic            illegal;
    } dec_t;

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [5:0]  fmt;
    logic        is_word;
    logic [63:0] imm64;
    logic        ill;
    dec_t        dec;

    assign opcode = in_inst[6:0];
    assign func3  = in_inst[14:12];

    // Format classification; RV64 word ops only exist when XLEN is 64
    always_comb begin
        fmt     = 6'b0;
        is_word = 1'b0;
        case (opcode)
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: fmt = FMT_I;
            OP_IMM32: begin
                fmt     = IS64 ? FMT_I : 6'b0;
                is_word = IS64;
            end
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_BRANCH:        fmt = FMT_B;
            OP_JAL:           fmt = FMT_J;
            OP_STORE:         fmt = FMT_S;
            OP_REG:           fmt = FMT_R;
            OP_REG32: begin
                fmt     = IS64 ? FMT_R : 6'b0;
                is_word = IS64;
            end
            default: fmt = 6'b0;
        endcase
    end

    // Immediates are built at 64 bits and truncated to XLEN
    always_comb begin
        imm64 = 64'b0;
        case (fmt)
            FMT_I: imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
            FMT_S: imm64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: imm64 = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                            in_inst[11:8], 1'b0};
            FMT_U: imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
            FMT_J: imm64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                            in_inst[30:21], 1'b0};
            default: imm64 = 64'b0;
        endcase
    end

`ifdef YSYX_23060278_DEC_ILLEGAL_EN
    always_comb begin
        ill = (in_inst[1:0] != 2'b11) || (fmt == 6'b0);
        case (opcode)
            OP_BRANCH: if (func3 == 3'b010 || func3 == 3'b011) ill = 1'b1;
            OP_LOAD:   if (func3 == 3'b111 ||
                           (!IS64 && (func3 == 3'b011 || func3 == 3'b110))) ill = 1'b1;
            OP_STORE:  if (func3[2] || (!IS64 && func3 == 3'b011)) ill = 1'b1;
            OP_JALR:   if (func3 != 3'b000) ill = 1'b1;
            default:   ;
        endcase
    end
`else
    assign ill = 1'b0;
`endif

    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.opcode   = opcode;
        dec.func3    = func3;
        dec.func7    = in_inst[31:25];
        dec.rs1      = in_inst[19:15];
        dec.rs2      = in_inst[24:20];
        dec.rd       = in_inst[11:7];
        dec.imm      = imm64[XLEN-1:0];
        dec.imm_type = fmt;
        dec.word     = is_word;
        dec.illegal  = ill;
    end

    dec_t oreg_q, oreg_d, sreg_q, sreg_d;
    logic oreg_v_q, oreg_v_d, sreg_v_q, sreg_v_d;
    logic in_ready_q;
    logic in_fire, out_fire;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = oreg_v_q && out_ready;

    // OREG refills from SREG first; in_ready is low whenever SREG holds an entry
    always_comb begin
        oreg_d   = oreg_q;
        sreg_d   = sreg_q;
        oreg_v_d = oreg_v_q;
        sreg_v_d = sreg_v_q;
        if (flush) begin
            oreg_v_d = 1'b0;
            sreg_v_d = 1'b0;
        end else if (!oreg_v_q || out_fire) begin
            if (sreg_v_q) begin
                oreg_d   = sreg_q;
                oreg_v_d = 1'b1;
                sreg_v_d = 1'b0;
            end else if (in_fire) begin
                oreg_d   = dec;
                oreg_v_d = 1'b1;
            end else begin
                oreg_v_d = 1'b0;
            end
        end else if (in_fire) begin
            sreg_d   = dec;
            sreg_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oreg_q     <= '0;
            sreg_q     <= '0;
            oreg_v_q   <= 1'b0;
            sreg_v_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            oreg_q     <= oreg_d;
            sreg_q     <= sreg_d;
            oreg_v_q   <= oreg_v_d;
            sreg_v_q   <= sreg_v_d;
            in_ready_q <= !sreg_v_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = oreg_v_q;
    assign out_pc       = oreg_q.pc;
    assign out_opcode   = oreg_q.opcode;
    assign out_func3    = oreg_q.func3;
    assign out_func7    = oreg_q.func7;
    assign out_rs1      = oreg_q.rs1;
    assign out_rs2      = oreg_q.rs2;
    assign out_rd       = oreg_q.rd;
    assign out_imm      = oreg_q.imm;
    assign out_imm_type = oreg_q.imm_type;
    assign out_word     = oreg_q.word;
    assign out_illegal  = oreg_q.illegal;

endmodule

// File: tb/tb_ysyx_23060278_decode_stage.sv
// Bench for the decode stage: XLEN=32 and XLEN=64 instances share one stimulus stream,
// checked against a queue model and a table-driven reference decoder.
module tb_ysyx_23060278_decode_stage;

    logic        clk;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        r32, v32, w32, il32;
    logic [31:0] pc32, imm32;
    logic [6:0]  op32, f7_32;
    logic [2:0]  f3_32;
    logic [4:0]  rs1_32, rs2_32, rd_32;
    logic [5:0]  ty32;

    logic        r64, v64, w64, il64;
    logic [63:0] pc64, imm64;
    logic [6:0]  op64, f7_64;
    logic [2:0]  f3_64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    logic [5:0]  ty64;

    int checks = 0;
    int errors = 0;

    ysyx_23060278_decode_stage #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
        .out_pc(pc32), .out_opcode(op32), .out_func3(f3_32), .out_func7(f7_32),
        .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd_32), .out_imm(imm32),
        .out_imm_type(ty32), .out_word(w32), .out_illegal(il32)
    );

    ysyx_23060278_decode_stage #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
        .out_pc(pc64), .out_opcode(op64), .out_func3(f3_64), .out_func7(f7_64),
        .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd_64), .out_imm(imm64),
        .out_imm_type(ty64), .out_word(w64), .out_illegal(il64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef YSYX_23060278_DEC_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] imm;
        logic [5:0]  ty;
        logic        word;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    bit   m_rdy = 1'b0;

    // Reference decoder: immediates from signed offset values, legality from the rule list
    function automatic exp_t ref_dec(input logic [31:0] inst, input logic [63:0] pc, input bit is64);
        exp_t e;
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        logic signed [31:0] s32;
        logic [2:0] f3;
        e = '0;
        f3 = inst[14:12];
        e.pc = is64 ? pc : {32'b0, pc[31:0]};
        e.op = inst[6:0]; e.f3 = f3; e.f7 = inst[31:25];
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
        case (inst[6:0])
            7'h67, 7'h03, 7'h13, 7'h73: begin e.ty = 6'b010000; s12 = inst[31:20]; e.imm = 64'(s12); end
            7'h1B: if (is64) begin e.ty = 6'b010000; s12 = inst[31:20]; e.imm = 64'(s12); e.word = 1'b1; end
            7'h37, 7'h17: begin e.ty = 6'b000010; s32 = {inst[31:12], 12'h000}; e.imm = 64'(s32); end
            7'h63: begin e.ty = 6'b000100;
                s13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; e.imm = 64'(s13); end
            7'h6F: begin e.ty = 6'b000001;
                s21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; e.imm = 64'(s21); end
            7'h23: begin e.ty = 6'b001000; s12 = {inst[31:25], inst[11:7]}; e.imm = 64'(s12); end
            7'h33: e.ty = 6'b100000;
            7'h3B: if (is64) begin e.ty = 6'b100000; e.word = 1'b1; end
            default: ;
        endcase
        if (ILL_EN)
            e.ill = (inst[1:0] != 2'b11) || (e.ty == 6'b0)
                 || (inst[6:0] == 7'h63 && (f3 == 3'd2 || f3 == 3'd3))
                 || (inst[6:0] == 7'h03 && (f3 == 3'd7 || (!is64 && (f3 == 3'd3 || f3 == 3'd6))))
                 || (inst[6:0] == 7'h23 && (f3 >= 3'd4 || (!is64 && f3 == 3'd3)))
                 || (inst[6:0] == 7'h67 && f3 != 3'd0);
        return e;
    endfunction

    // Advance one clock and update the depth-2 queue model; outputs are sampled 1 time unit later
    task automatic tick();
        bit ofire, ifire;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_rdy = 1'b0;
        end else begin
            ofire = (q.size() > 0) && out_ready;
            ifire = in_valid && m_rdy;
            if (flush) q.delete();
            else begin
                if (ofire) void'(q.pop_front());
                if (ifire) q.push_back('{inst: in_inst, pc: in_pc});
            end
            m_rdy = (q.size() < 2);
        end
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 64'h0;
        tick(); tick();
        checks++;
        if ({v32, v64, r32, r64} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {v32, v64, r32, r64});
        end
        checks++;
        if ({imm64, ty64, pc32, imm32} !== '0) begin
            errors++; $display("FAIL reset_regs: got imm64=%h ty=%b pc32=%h imm32=%h expected zeros",
                               imm64, ty64, pc32, imm32);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({r32, r64} !== 2'b11) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 11", {r32, r64});
        end
    endtask

    task automatic test_addi32();
        out_ready = 1'b1;
        offer(32'hFFF00093, 64'h8000_0000);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({v32, imm32, ty32, rd_32, rs1_32, il32} !== {1'b1, 32'hFFFF_FFFF, 6'b010000, 5'd1, 5'd0, 1'b0}) begin
            errors++; $display("FAIL addi32: got v=%b imm=%h ty=%b rd=%0d rs1=%0d ill=%b expected v=1 imm=ffffffff ty=010000 rd=1 rs1=0 ill=0",
                               v32, imm32, ty32, rd_32, rs1_32, il32);
        end
        tick();
    endtask

    task automatic test_rv64_imm();
        out_ready = 1'b1;
        offer(32'h123452B7, 64'h8000_0004);
        tick();
        checks++;
        if ({v64, imm64, rd_64, ty64} !== {1'b1, 64'h0000_0000_1234_5000, 5'd5, 6'b000010}) begin
            errors++; $display("FAIL lui64: got v=%b imm=%h rd=%0d ty=%b expected v=1 imm=0000000012345000 rd=5 ty=000010",
                               v64, imm64, rd_64, ty64);
        end
        offer(32'hFFDFF0EF, 64'h8000_0008);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({v64, imm64, ty64, pc64} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 6'b000001, 64'h8000_0008}) begin
            errors++; $display("FAIL jal64: got v=%b imm=%h ty=%b pc=%h expected v=1 imm=fffffffffffffffc ty=000001 pc=0000000080000008",
                               v64, imm64, ty64, pc64);
        end
        tick();
    endtask

    task automatic test_word();
        out_ready = 1'b1;
        offer(32'h0010009B, 64'h8000_0010);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({w64, imm64, il64, ty64} !== {1'b1, 64'd1, 1'b0, 6'b010000}) begin
            errors++; $display("FAIL addiw64: got word=%b imm=%h ill=%b ty=%b expected word=1 imm=1 ill=0 ty=010000",
                               w64, imm64, il64, ty64);
        end
        checks++;
        if ({w32, il32, ty32, imm32} !== {1'b0, ILL_EN, 6'b0, 32'd0}) begin
            errors++; $display("FAIL addiw32: got word=%b ill=%b ty=%b imm=%h expected word=0 ill=%b ty=000000 imm=0",
                               w32, il32, ty32, imm32, ILL_EN);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [63:0] base;
        base = 64'h1000;
        out_ready = 1'b0;
        offer(32'h00100093, base + 64'd4);
        tick();
        checks++;
        if ({v64, pc64, r64} !== {1'b1, base + 64'd4, 1'b1}) begin
            errors++; $display("FAIL bp_first: got v=%b pc=%h rdy=%b expected v=1 pc=%h rdy=1", v64, pc64, r64, base + 64'd4);
        end
        offer(32'h00200093, base + 64'd8);
        tick();
        checks++;
        if ({r32, r64, pc64} !== {2'b00, base + 64'd4}) begin
            errors++; $display("FAIL bp_skid_full: got rdy=%b%b pc=%h expected rdy=00 pc=%h", r32, r64, pc64, base + 64'd4);
        end
        offer(32'h00300093, base + 64'd12);
        tick();
        checks++;
        if ({v64, pc64, imm64, r64} !== {1'b1, base + 64'd4, 64'd1, 1'b0}) begin
            errors++; $display("FAIL bp_hold: got v=%b pc=%h imm=%h rdy=%b expected v=1 pc=%h imm=1 rdy=0",
                               v64, pc64, imm64, r64, base + 64'd4);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({v64, pc64, imm64, r64} !== {1'b1, base + 64'd8, 64'd2, 1'b1}) begin
            errors++; $display("FAIL bp_second: got v=%b pc=%h imm=%h rdy=%b expected v=1 pc=%h imm=2 rdy=1",
                               v64, pc64, imm64, r64, base + 64'd8);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({v32, pc32, imm32} !== {1'b1, 32'h100C, 32'd3}) begin
            errors++; $display("FAIL bp_third: got v=%b pc=%h imm=%h expected v=1 pc=0000100c imm=3", v32, pc32, imm32);
        end
        tick();
        checks++;
        if ({v32, v64} !== 2'b00) begin
            errors++; $display("FAIL bp_drained: got %b expected 00", {v32, v64});
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h00100093, 64'h2000);
        tick();
        offer(32'h00200093, 64'h2004);
        tick();
        flush = 1'b1;
        offer(32'h7FF00093, 64'hDEAD_0000);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({v32, v64, r32, r64} !== 4'b0011) begin
            errors++; $display("FAIL flush_state: got v=%b%b rdy=%b%b expected v=00 rdy=11", v32, v64, r32, r64);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (v64 !== 1'b0) begin
                errors++; $display("FAIL flush_dropped: cycle %0d got v=%b pc=%h expected v=0", i, v64, pc64);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(32'h00100093, 64'h3000);
        tick();
        offer(32'h00200093, 64'h3004);
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        checks++;
        if ({v32, v64, imm32, imm64} !== '0) begin
            errors++; $display("FAIL rst_mid: got v=%b%b imm32=%h imm64=%h expected zeros", v32, v64, imm32, imm64);
        end
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        offer(32'h00500093, 64'h3008);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({v64, imm64, pc64} !== {1'b1, 64'd5, 64'h3008}) begin
            errors++; $display("FAIL rst_resume: got v=%b imm=%h pc=%h expected v=1 imm=5 pc=3008", v64, imm64, pc64);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [12];
        logic [31:0] inst;
        logic [103:0] g32, x32;
        logic [167:0] g64, x64;
        exp_t e;
        ops = '{7'h67, 7'h03, 7'h13, 7'h73, 7'h1B, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h23, 7'h33, 7'h3B};
        for (int c = 0; c < 800; c++) begin
            inst = $urandom;
            if ($urandom_range(0, 13) < 12) inst[6:0] = ops[$urandom_range(0, 11)];
            in_inst   = inst;
            in_pc     = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
            checks++;
            if ({v32, v64, r32, r64} !== {(q.size() > 0), (q.size() > 0), m_rdy, m_rdy}) begin
                errors++; $display("FAIL rand_ctrl: cycle %0d got v=%b%b rdy=%b%b expected v=%0d rdy=%0d",
                                   c, v32, v64, r32, r64, q.size() > 0, m_rdy);
            end
            if (q.size() > 0) begin
                e = ref_dec(q[0].inst, q[0].pc, 1'b0);
                g32 = {pc32, op32, f3_32, f7_32, rs1_32, rs2_32, rd_32, imm32, ty32, w32, il32};
                x32 = {e.pc[31:0], e.op, e.f3, e.f7, e.rs1, e.rs2, e.rd, e.imm[31:0], e.ty, e.word, e.ill};
                checks++;
                if (g32 !== x32) begin
                    errors++; $display("FAIL rand_bundle32: cycle %0d inst=%h got %h expected %h", c, q[0].inst, g32, x32);
                end
                e = ref_dec(q[0].inst, q[0].pc, 1'b1);
                g64 = {pc64, op64, f3_64, f7_64, rs1_64, rs2_64, rd_64, imm64, ty64, w64, il64};
                x64 = {e.pc, e.op, e.f3, e.f7, e.rs1, e.rs2, e.rd, e.imm, e.ty, e.word, e.ill};
                checks++;
                if (g64 !== x64) begin
                    errors++; $display("FAIL rand_bundle64: cycle %0d inst=%h got %h expected %h", c, q[0].inst, g64, x64);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi32();
        test_rv64_imm();
        test_word();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
